// File: rtl/mem_serial_ctrl.sv
// Serialises byte/half/word/double loads and stores onto a one-bit-wide RAM.
// Loads take one bit per cycle; stores use a setup/strobe pair per bit.
module mem_serial_ctrl #(
  parameter int MADDR_SZ = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [MADDR_SZ-1:0] req_addr,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [63:0]         req_wdata,
  output logic                resp_valid,
  output logic [63:0]         resp_rdata,
  output logic                resp_err,
  output logic [MADDR_SZ-1:0] ram_addr,
  output logic                ram_din,
  output logic                ram_we,
  input  logic                ram_dout
);

  typedef enum logic [2:0] {IDLE, READ, WSETUP, WSTROBE, DONE} state_t;

  state_t              state, state_nxt;
  logic [MADDR_SZ-1:0] base_q, hold_addr_q, cur_addr;
  logic [1:0]          size_q;
  logic                signed_q, we_q, err_q, hold_din_q, cur_din;
  logic [63:0]         wdata_q, data_q, data_ext;
  logic [5:0]          cnt_q, last_cnt;
  logic [2:0]          align_mask;
  logic                accept, misaligned, last_bit, active, writing;

  // The top three byte-address bits fall off the bit address by construction.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[MADDR_SZ-1 -: 3];

  assign accept     = req_valid & req_ready;
  assign misaligned = |(req_addr[2:0] & align_mask);
  assign last_bit   = (cnt_q == last_cnt);
  assign active     = (state == READ) || (state == WSETUP) || (state == WSTROBE);
  assign writing    = (state == WSETUP) || (state == WSTROBE);
  assign cur_addr   = base_q + MADDR_SZ'(cnt_q);
  assign cur_din    = wdata_q[cnt_q];

  // NOTE: every always_comb assigns each output a default first so no latch is inferred.
  always_comb begin
    align_mask = 3'b000;
    case (req_size)
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      2'd3:    align_mask = 3'b111;
      default: align_mask = 3'b000;
    endcase
  end

  always_comb begin
    last_cnt = 6'd7;
    data_ext = data_q;
    case (size_q)
      2'd0: begin
        last_cnt = 6'd7;
        data_ext = {{56{signed_q & data_q[7]}}, data_q[7:0]};
      end
      2'd1: begin
        last_cnt = 6'd15;
        data_ext = {{48{signed_q & data_q[15]}}, data_q[15:0]};
      end
      2'd2: begin
        last_cnt = 6'd31;
        data_ext = {{32{signed_q & data_q[31]}}, data_q[31:0]};
      end
      default: begin
        last_cnt = 6'd63;
        data_ext = data_q;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = misaligned ? DONE : (req_we ? WSETUP : READ);
      READ:    if (last_bit) state_nxt = DONE;
      WSETUP:  state_nxt = WSTROBE;
      WSTROBE: state_nxt = last_bit ? DONE : WSETUP;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data hold their last driven value whenever no access is in flight.
  always_comb begin
    req_ready  = (state == IDLE) & ~rst;
    ram_we     = (state == WSTROBE);
    resp_valid = (state == DONE);
    resp_err   = (state == DONE) & err_q;
    resp_rdata = ((state == DONE) && !err_q && !we_q) ? data_ext : 64'd0;
    ram_addr   = active  ? cur_addr : hold_addr_q;
    ram_din    = writing ? cur_din  : hold_din_q;
  end

  // NOTE: the captured-data register is reset too, so an aborted load leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      base_q      <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= '0;
      data_q      <= '0;
      hold_addr_q <= '0;
      hold_din_q  <= 1'b0;
    end else begin
      if (accept) begin
        base_q   <= {req_addr[MADDR_SZ-4:0], 3'b000};
        size_q   <= req_size;
        signed_q <= req_signed;
        we_q     <= req_we;
        err_q    <= misaligned;
        wdata_q  <= req_wdata;
        cnt_q    <= '0;
      end
      if (active)  hold_addr_q <= cur_addr;
      if (writing) hold_din_q  <= cur_din;
      if (state == READ) begin
        data_q[cnt_q] <= ram_dout;
        cnt_q         <= cnt_q + 6'd1;
      end
      if (state == WSTROBE && !last_bit) cnt_q <= cnt_q + 6'd1;
    end
  end

endmodule
